rom_read_arbiter: RTL and testbench
===================================

# rom_read_arbiter

Two-master AXI read-channel arbiter that shares the single boot-ROM read port (the ROM wrapper's AR/R slave interface) between the instruction-fetch and data-access masters. It grants one master per burst using round-robin priority and holds the grant from AR handshake until the last R beat. It forwards AR and R traffic combinationally from the registered grant and checks burst length against RLAST.

## Interface
Parameters:
- ADDR_W, 32, address width of AR channels
- DATA_W, 32, read data width

Ports:
- clock  in  1  single clock for all logic
- reset  in  1  synchronous, active-high reset
- m_arvalid  in  2  per-master ARVALID, bit i = master i
- m_araddr  in  2*ADDR_W  packed per-master ARADDR, master i at [i*ADDR_W +: ADDR_W]
- m_arlen  in  8  packed per-master ARLEN (4 bits each)
- m_arready  out  2  per-master ARREADY
- m_rvalid  out  2  per-master RVALID
- m_rready  in  2  per-master RREADY
- m_rdata  out  DATA_W  read data broadcast to both masters, qualified by m_rvalid
- m_rlast  out  1  RLAST broadcast, qualified by m_rvalid
- s_arvalid  out  1  ARVALID to ROM slave
- s_araddr  out  ADDR_W  ARADDR to ROM slave
- s_arlen  out  4  ARLEN to ROM slave
- s_arready  in  1  ARREADY from ROM slave
- s_rvalid  in  1  RVALID from ROM slave
- s_rdata  in  DATA_W  RDATA from ROM slave
- s_rlast  in  1  RLAST from ROM slave
- s_rready  out  1  RREADY to ROM slave
- burst_err  out  1  one-cycle pulse on burst length mismatch

## Operation
- FSM states: IDLE, ADDR, DATA. Registers: state, grant (1 bit), last_grant (1 bit), len_q (4 bits), beat_cnt (4 bits), burst_err.
- IDLE: all handshake outputs 0.
  - If any m_arvalid is set, grant the requester. If both request, grant = ~last_grant.
  - Latch m_arlen of the winner into len_q, clear beat_cnt, go to ADDR.
- ADDR: s_arvalid/s_araddr/s_arlen = granted master's signals. m_arready[grant] = s_arready; the other bit is 0.
  - On s_arvalid & s_arready, go to DATA.
- DATA: m_rvalid[grant] = s_rvalid; the other bit is 0. s_rready = m_rready[grant]. m_rdata/m_rlast = s_rdata/s_rlast.
  - Each beat (s_rvalid & s_rready) increments beat_cnt.
  - On a beat with s_rlast: go to IDLE and set last_grant = grant. burst_err pulses if beat_cnt != len_q.
  - On a beat without s_rlast where beat_cnt == len_q: burst_err pulses, and the controller stays in DATA until s_rlast.
- Non-granted master requests are held pending. Masters must keep ARVALID and ARADDR stable until handshake (AXI rule).
- beat_cnt is 4 bits and must not wrap silently. It saturates at 15.

## Timing
- Reset values: state = IDLE, last_grant = 1 (master 0 wins the first tie), grant = 0, beat_cnt = 0, burst_err = 0.
  - All outputs are 0 at reset: m_arready, m_rvalid, m_rdata, m_rlast, s_arvalid, s_araddr, s_arlen, s_rready.
- Reset asserted in any state: next cycle all outputs are at reset values and any in-flight burst is abandoned. The ROM slave is reset in the same cycle.
- Arbitration latency: m_arvalid seen in IDLE at cycle N gives s_arvalid = 1 at cycle N+1.
- Minimum gap between bursts: 1 IDLE cycle after the RLAST beat.
- Routing is combinational from registered state/grant, so there is no extra pipeline latency on AR or R.
- burst_err is registered. It is high exactly one cycle, the cycle after the offending beat.
- A master that raises m_arvalid in the cycle the other master's RLAST completes is arbitrated in the following IDLE cycle.

## Test plan
- Reset: hold reset 3 cycles -> all outputs 0, state IDLE. The first simultaneous request is granted to master 0.
- Single read: m_arvalid = 01, m_araddr[31:0] = 0x0000_0010, len 0 -> s_arvalid = 1 with addr 0x10 next cycle. Slave returns 0xDEADBEEF with rlast -> m_rvalid = 01, m_rdata = 0xDEADBEEF, burst_err = 0.
- Contention: both request, len 0 each -> master 0 served first, then master 1. Repeat with both requesting -> master 1... wait, last_grant = 1 after the second burst -> master 0 next. Grants alternate 0,1,0,1.
- Burst with backpressure: master 1 requests len 3 while m_rready toggles 1,0,1,0 -> 4 beats delivered only to master 1. m_arready[0] = 0 and m_rvalid[0] = 0 throughout. Return to IDLE after the 4th beat.
- Length error: master 0 requests len 3, slave asserts s_rlast on beat 2 -> burst_err pulses for 1 cycle and the FSM returns to IDLE.
- Mid-burst reset: assert reset during DATA beat 1 -> next cycle all outputs 0. After release, a request from master 1 alone is granted with s_arvalid at N+1.

Source files
------------

// File: rtl/rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// rom_read_arbiter
//
// Shares the boot-ROM read port (AXI AR/R slave) between two read masters:
// master 0 is instruction fetch and master 1 is data access. One master owns
// the port for a whole burst. The grant is taken in IDLE, held through the AR
// handshake (ADDR), and released on the RLAST beat (DATA). When both masters
// request in the same cycle, round-robin picks the one that was not served
// last.
//
// AR and R signals are steered combinationally from the registered state and
// grant, so the arbiter adds no pipeline latency on either channel. Every R
// beat is counted. A burst whose RLAST does not land on beat ARLEN raises a
// one-cycle burst_err pulse.
//
// Ports
//   clock, reset          clock; synchronous active-high reset
//   m_arvalid/m_arready   per-master AR handshake (bit i = master i)
//   m_araddr              packed per-master ARADDR, master i at [i*ADDR_W +: ADDR_W]
//   m_arlen               packed per-master ARLEN, master i at [i*4 +: 4]
//   m_rvalid/m_rready     per-master R handshake
//   m_rdata, m_rlast      R payload broadcast to both masters, qualified by m_rvalid
//   s_ar*                 AR channel to the ROM slave
//   s_r*                  R channel from the ROM slave
//   burst_err             one-cycle pulse after a beat that breaks the burst length
// ---------------------------------------------------------------------------
module rom_read_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          m_arvalid,
  input  logic [2*ADDR_W-1:0] m_araddr,
  input  logic [7:0]          m_arlen,
  output logic [1:0]          m_arready,
  output logic [1:0]          m_rvalid,
  input  logic [1:0]          m_rready,
  output logic [DATA_W-1:0]   m_rdata,
  output logic                m_rlast,
  output logic                s_arvalid,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic [3:0]          s_arlen,
  input  logic                s_arready,
  input  logic                s_rvalid,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic                s_rlast,
  output logic                s_rready,
  output logic                burst_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        grant, grant_nxt;
  logic        last_grant, last_grant_nxt;
  logic [3:0]  len_q, len_nxt;
  logic [3:0]  beat_cnt, beat_nxt;
  logic        burst_err_nxt;

  logic        win;
  logic        beat;
  logic [ADDR_W-1:0] sel_addr;
  logic [3:0]        sel_len;

  // The beat counter must never wrap back to a value that could falsely
  // match len_q on an overlong burst, so it sticks at its maximum.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // On a tie, the master that was not served last wins. Otherwise the
  // single requester wins.
  assign win = (&m_arvalid) ? ~last_grant : m_arvalid[1];

  assign sel_addr = grant ? m_araddr[2*ADDR_W-1:ADDR_W] : m_araddr[ADDR_W-1:0];
  assign sel_len  = grant ? m_arlen[7:4] : m_arlen[3:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      beat_cnt   <= 4'd0;
      burst_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_nxt;
      burst_err  <= burst_err_nxt;
    end
  end

  // len_q is only consulted in DATA, after IDLE has loaded it, so it needs
  // no reset.
  always_ff @(posedge clock) begin
    len_q <= len_nxt;
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    len_nxt        = len_q;
    beat_nxt       = beat_cnt;
    burst_err_nxt  = 1'b0;
    beat           = 1'b0;

    m_arready = 2'b00;
    m_rvalid  = 2'b00;
    m_rdata   = '0;
    m_rlast   = 1'b0;
    s_arvalid = 1'b0;
    s_araddr  = '0;
    s_arlen   = 4'd0;
    s_rready  = 1'b0;

    case (state)
      IDLE: begin
        if (|m_arvalid) begin
          grant_nxt = win;
          len_nxt   = win ? m_arlen[7:4] : m_arlen[3:0];
          beat_nxt  = 4'd0;
          state_nxt = ADDR;
        end
      end

      ADDR: begin
        s_arvalid        = 1'b1;
        s_araddr         = sel_addr;
        s_arlen          = sel_len;
        m_arready[grant] = s_arready;
        if (s_arready) begin
          state_nxt = DATA;
        end
      end

      DATA: begin
        m_rvalid[grant] = s_rvalid;
        s_rready        = m_rready[grant];
        m_rdata         = s_rdata;
        m_rlast         = s_rlast;
        // The beat is computed from the inputs here rather than from the
        // s_rready output, so the block does not feed back on itself.
        beat            = s_rvalid & m_rready[grant];
        if (beat) begin
          beat_nxt = sat_inc(beat_cnt);
          if (s_rlast) begin
            // beat_cnt still holds the index of this beat, which must equal
            // ARLEN for a correctly sized burst.
            burst_err_nxt  = (beat_cnt != len_q);
            last_grant_nxt = grant;
            state_nxt      = IDLE;
          end else if (beat_cnt == len_q) begin
            // The expected final beat came without RLAST. Flag it once and
            // keep draining until the slave does end the burst.
            burst_err_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rom_read_arbiter
//
// Directed bench for rom_read_arbiter. The bench plays the ROM slave and both
// masters by hand. Inputs change 1 ns after the rising edge. Outputs are
// checked a further 1 ns later, or 1 ns after an edge.
// ---------------------------------------------------------------------------
module tb_rom_read_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h2000_0040;

  logic                clock = 1'b0;
  logic                reset;
  logic [1:0]          m_arvalid;
  logic [2*ADDR_W-1:0] m_araddr;
  logic [7:0]          m_arlen;
  logic [1:0]          m_arready;
  logic [1:0]          m_rvalid;
  logic [1:0]          m_rready;
  logic [DATA_W-1:0]   m_rdata;
  logic                m_rlast;
  logic                s_arvalid;
  logic [ADDR_W-1:0]   s_araddr;
  logic [3:0]          s_arlen;
  logic                s_arready;
  logic                s_rvalid;
  logic [DATA_W-1:0]   s_rdata;
  logic                s_rlast;
  logic                s_rready;
  logic                burst_err;

  int checks = 0;
  int errors = 0;

  rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock     (clock),
    .reset     (reset),
    .m_arvalid (m_arvalid),
    .m_araddr  (m_araddr),
    .m_arlen   (m_arlen),
    .m_arready (m_arready),
    .m_rvalid  (m_rvalid),
    .m_rready  (m_rready),
    .m_rdata   (m_rdata),
    .m_rlast   (m_rlast),
    .s_arvalid (s_arvalid),
    .s_araddr  (s_araddr),
    .s_arlen   (s_arlen),
    .s_arready (s_arready),
    .s_rvalid  (s_rvalid),
    .s_rdata   (s_rdata),
    .s_rlast   (s_rlast),
    .s_rready  (s_rready),
    .burst_err (burst_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Every output must read zero: used in reset and while idle.
  task automatic chk_quiet(input string tag);
    chk({tag, "_arready"}, m_arready, 0);
    chk({tag, "_rvalid"},  m_rvalid,  0);
    chk({tag, "_rdata"},   m_rdata,   0);
    chk({tag, "_rlast"},   m_rlast,   0);
    chk({tag, "_s_arv"},   s_arvalid, 0);
    chk({tag, "_s_addr"},  s_araddr,  0);
    chk({tag, "_s_len"},   s_arlen,   0);
    chk({tag, "_s_rrdy"},  s_rready,  0);
  endtask

  // One well-formed burst. req is OR-ed into the pending requests. The
  // granted master drops ARVALID after its AR handshake. The slave returns
  // nbeats beats of base+i with RLAST on the last one, and the master is
  // always ready.
  task automatic burst(input string tag, input logic [1:0] req, input logic exp_g,
                       input logic [3:0] len, input int nbeats, input logic [31:0] base);
    m_arvalid = m_arvalid | req;
    m_arlen   = {len, len};
    #1;
    chk({tag, "_idle_arv"}, s_arvalid, 0);
    tick();
    chk({tag, "_arvalid"}, s_arvalid, 1);
    chk({tag, "_araddr"},  s_araddr, exp_g ? A1 : A0);
    chk({tag, "_arlen"},   s_arlen, len);
    s_arready = 1'b1;
    #1;
    chk({tag, "_arready"}, m_arready, exp_g ? 2'b10 : 2'b01);
    tick();
    s_arready        = 1'b0;
    m_arvalid[exp_g] = 1'b0;
    m_rready         = 2'b11;
    for (int b = 0; b < nbeats; b++) begin
      s_rvalid = 1'b1;
      s_rdata  = base + b;
      s_rlast  = (b == nbeats - 1);
      #1;
      chk({tag, "_rvalid"}, m_rvalid, exp_g ? 2'b10 : 2'b01);
      chk({tag, "_rdata"},  m_rdata, base + b);
      chk({tag, "_rlast"},  m_rlast, (b == nbeats - 1));
      tick();
      chk({tag, "_err"}, burst_err, 0);
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = 2'b00;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles while every input is busy.
    reset     = 1'b1;
    m_arvalid = 2'b11;
    m_araddr  = {A1, A0};
    m_arlen   = 8'h00;
    m_rready  = 2'b11;
    s_arready = 1'b1;
    s_rvalid  = 1'b1;
    s_rdata   = 32'hFFFF_FFFF;
    s_rlast   = 1'b1;
    tick(); tick(); tick();
    chk_quiet("rst");
    chk("rst_err", burst_err, 0);

    reset     = 1'b0;
    m_arvalid = 2'b00;
    m_rready  = 2'b00;
    s_arready = 1'b0;
    s_rvalid  = 1'b0;
    s_rdata   = '0;
    s_rlast   = 1'b0;

    // Contention: both masters keep requesting. Grants go 0, 1, 0, 1.
    burst("rr0", 2'b11, 1'b0, 4'd0, 1, 32'h1000_0000);
    burst("rr1", 2'b01, 1'b1, 4'd0, 1, 32'h1100_0000);
    burst("rr2", 2'b10, 1'b0, 4'd0, 1, 32'h1200_0000);
    burst("rr3", 2'b01, 1'b1, 4'd0, 1, 32'h1300_0000);
    m_arvalid = 2'b00;

    // Single read from master 0.
    burst("single", 2'b01, 1'b0, 4'd0, 1, 32'hDEAD_BEEF);
    chk_quiet("single_idle");

    // Backpressure: the tie goes to master 1 (last served was 0). Master 1
    // reads 4 beats while its RREADY toggles 1,0,1,0. Master 0 stays pending.
    m_arvalid = 2'b11;
    m_arlen   = {4'd3, 4'd0};
    tick();
    chk("bp_araddr", s_araddr, A1);
    chk("bp_arlen",  s_arlen, 4'd3);
    s_arready = 1'b1;
    #1;
    chk("bp_arready", m_arready, 2'b10);
    tick();
    s_arready = 1'b0;
    m_arvalid = 2'b01;
    begin
      int b;
      b = 0;
      for (int k = 0; k < 7; k++) begin
        m_rready = (k % 2 == 0) ? 2'b11 : 2'b01;
        s_rvalid = 1'b1;
        s_rdata  = 32'hB000_0000 + b;
        s_rlast  = (b == 3);
        #1;
        chk("bp_rvalid", m_rvalid, 2'b10);
        chk("bp_rready", s_rready, m_rready[1]);
        chk("bp_arrdy0", m_arready, 2'b00);
        chk("bp_rdata",  m_rdata, 32'hB000_0000 + b);
        tick();
        if (k % 2 == 0) b++;
      end
    end
    m_arvalid = 2'b00;
    chk("bp_end_rvalid", m_rvalid, 2'b00);
    chk("bp_end_rready", s_rready, 0);
    chk("bp_end_err",    burst_err, 0);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = 2'b00;

    // Length error: master 0 asks for 4 beats but RLAST arrives on the third.
    m_arvalid = 2'b01;
    m_arlen   = {4'd0, 4'd3};
    tick();
    chk("le_araddr", s_araddr, A0);
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    m_arvalid = 2'b00;
    m_rready  = 2'b01;
    for (int b = 0; b < 3; b++) begin
      s_rvalid = 1'b1;
      s_rdata  = 32'hE000_0000 + b;
      s_rlast  = (b == 2);
      tick();
      chk("le_err", burst_err, (b == 2));
    end
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    chk("le_idle_rvalid", m_rvalid, 2'b00);
    tick();
    chk("le_err_drop", burst_err, 0);

    // Missing RLAST: one beat expected. Beat 0 lacks RLAST, which flags once;
    // beat 1 ends the burst at the wrong count, which flags again.
    m_arvalid = 2'b10;
    m_arlen   = {4'd0, 4'd0};
    tick();
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    m_arvalid = 2'b00;
    m_rready  = 2'b10;
    s_rvalid  = 1'b1;
    s_rlast   = 1'b0;
    tick();
    chk("nl_err0", burst_err, 1);
    s_rvalid = 1'b0;
    tick();
    chk("nl_gap", burst_err, 0);
    chk("nl_still_data", s_rready, 1);
    s_rvalid = 1'b1;
    s_rlast  = 1'b1;
    tick();
    chk("nl_err1", burst_err, 1);
    s_rvalid = 1'b0;
    s_rlast  = 1'b0;
    m_rready = 2'b00;

    // Reset during the second beat of a burst.
    m_arvalid = 2'b01;
    m_arlen   = {4'd0, 4'd3};
    tick();
    s_arready = 1'b1;
    tick();
    s_arready = 1'b0;
    m_arvalid = 2'b00;
    m_rready  = 2'b11;
    s_rvalid  = 1'b1;
    s_rdata   = 32'hA5A5_0000;
    tick();
    s_rdata   = 32'hA5A5_0001;
    #1;
    chk("mr_beat1", m_rvalid, 2'b01);
    reset = 1'b1;
    tick();
    chk_quiet("mr");
    reset     = 1'b0;
    s_rvalid  = 1'b0;
    m_rready  = 2'b00;
    m_arvalid = 2'b10;
    #1;
    chk("mr_idle_arv", s_arvalid, 0);
    tick();
    chk("mr_arvalid", s_arvalid, 1);
    chk("mr_araddr",  s_araddr, A1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
